frame_scanout_ctrl: RTL and testbench

//  Downstream read sequencer for the two 24-bit frame buffers (buffer 1 / buffer 2). Waits for a

---
 rtl/frame_scanout_ctrl.sv | 165 ++++++++++++++++
 tb/tb_frame_scanout_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_scanout_ctrl.sv
// Ping-pong frame buffer read sequencer: rasters a full buffer out as a pixel stream
// with valid/hsync/vsync, alternating between buffers when both hold frames.
module frame_scanout_ctrl #(
  parameter int unsigned H_ACTIVE = 100,
  parameter int unsigned H_BLANK  = 20,
  parameter int unsigned V_ACTIVE = 100,
  parameter int unsigned V_BLANK  = 5,
  parameter int unsigned ADDR_W   = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              buf1_full,
  input  logic              buf2_full,
  output logic              re1,
  output logic              re2,
  output logic [ADDR_W-1:0] addr,
  input  logic [7:0]        r1,
  input  logic [7:0]        g1,
  input  logic [7:0]        b1,
  input  logic [7:0]        r2,
  input  logic [7:0]        g2,
  input  logic [7:0]        b2,
  output logic [7:0]        pix_r,
  output logic [7:0]        pix_g,
  output logic [7:0]        pix_b,
  output logic              pix_valid,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_done,
  output logic              active_buf
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_BLANK;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_BLANK;
  localparam int unsigned X_W      = $clog2(H_TOTAL);
  localparam int unsigned Y_W      = $clog2(V_TOTAL);
  localparam int unsigned PIX_LAST = H_ACTIVE * V_ACTIVE - 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              active_buf_q, active_buf_d;
  logic              buf_dly_q, buf_dly_d;
  logic              re1_q, re1_d;
  logic              re2_q, re2_d;
  logic              pix_valid_q, pix_valid_d;
  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;

  logic start, line_end, frame_end, read_next;

  // Next state; re/addr are computed from the next x/y so they line up with the scan position.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    addr_d       = addr_q;
    active_buf_d = active_buf_q;
    start        = 1'b0;
    line_end     = (x_q == X_W'(H_TOTAL - 1));
    frame_end    = line_end && (y_q == Y_W'(V_TOTAL - 1));

    case (state_q)
      S_IDLE: begin
        if (buf1_full) begin
          start        = 1'b1;
          active_buf_d = 1'b0;
        end else if (buf2_full) begin
          start        = 1'b1;
          active_buf_d = 1'b1;
        end
      end
      S_SCAN: begin
        if ((re1_q || re2_q) && (addr_q != ADDR_W'(PIX_LAST))) begin
          addr_d = addr_q + ADDR_W'(1);
        end
        if (line_end) begin
          x_d = '0;
          if (frame_end) begin
            y_d     = '0;
            state_d = S_DONE;
          end else begin
            y_d = y_q + Y_W'(1);
          end
        end else begin
          x_d = x_q + X_W'(1);
        end
      end
      S_DONE: begin
        if (active_buf_q ? buf1_full : buf2_full) begin
          start        = 1'b1;
          active_buf_d = ~active_buf_q;
        end else if (active_buf_q ? buf2_full : buf1_full) begin
          start = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start) begin
      state_d = S_SCAN;
      x_d     = '0;
      y_d     = '0;
      addr_d  = '0;
    end

    read_next   = (state_d == S_SCAN) && (x_d < X_W'(H_ACTIVE)) && (y_d < Y_W'(V_ACTIVE));
    re1_d       = read_next && !active_buf_d;
    re2_d       = read_next && active_buf_d;
    pix_valid_d = re1_q || re2_q;
    buf_dly_d   = active_buf_q;
    hsync_d     = (state_q == S_SCAN) && line_end;
    vsync_d     = (state_q == S_SCAN) && frame_end;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= '0;
      active_buf_q <= 1'b0;
      buf_dly_q    <= 1'b0;
      re1_q        <= 1'b0;
      re2_q        <= 1'b0;
      pix_valid_q  <= 1'b0;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      addr_q       <= addr_d;
      active_buf_q <= active_buf_d;
      buf_dly_q    <= buf_dly_d;
      re1_q        <= re1_d;
      re2_q        <= re2_d;
      pix_valid_q  <= pix_valid_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
    end
  end

  // Buffer read data arrives one cycle after re, aligned with pix_valid.
  assign pix_r = pix_valid_q ? (buf_dly_q ? r2 : r1) : 8'd0;
  assign pix_g = pix_valid_q ? (buf_dly_q ? g2 : g1) : 8'd0;
  assign pix_b = pix_valid_q ? (buf_dly_q ? b2 : b1) : 8'd0;

  assign re1        = re1_q;
  assign re2        = re2_q;
  assign addr       = addr_q;
  assign pix_valid  = pix_valid_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign frame_done = vsync_q;
  assign active_buf = active_buf_q;

endmodule

// File: tb/tb_frame_scanout_ctrl.sv
// Bench for frame_scanout_ctrl: start-of-frame vector table plus full-frame raster model
// covering repeat, ping-pong, mid-frame flag clear, mid-frame reset and tie-break.
module tb_frame_scanout_ctrl;

  logic        clk;
  logic        reset;
  logic        buf1_full, buf2_full;
  logic        re1, re2;
  logic [19:0] addr;
  logic [7:0]  r1, g1, b1, r2, g2, b2;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic        pix_valid, hsync, vsync, frame_done, active_buf;

  int passed = 0;
  int total  = 0;
  int inv_err = 0;

  frame_scanout_ctrl dut (
    .clk(clk), .reset(reset), .buf1_full(buf1_full), .buf2_full(buf2_full),
    .re1(re1), .re2(re2), .addr(addr),
    .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .pix_valid(pix_valid),
    .hsync(hsync), .vsync(vsync), .frame_done(frame_done), .active_buf(active_buf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer models: one-cycle read latency, data derived from the read address.
  always @(posedge clk) begin
    if (re1) begin
      r1 <= addr[7:0];
      g1 <= addr[15:8];
      b1 <= 8'hA5;
    end
    if (re2) begin
      r2 <= ~addr[7:0];
      g2 <= addr[15:8];
      b2 <= 8'h5A;
    end
  end

  always @(negedge clk) begin
    if (re1 && re2) inv_err++;
    if (addr > 20'd9999) inv_err++;
  end

  typedef struct {
    logic        re1;
    logic        re2;
    logic [19:0] addr;
    logic        pv;
    logic [7:0]  pr;
    logic        hs;
  } vec_t;

  vec_t tbl[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Walks the remainder of a frame from scan cycle c0 (x=0,y=0 is c=0) to the DONE cycle.
  task automatic scan_frame(input logic exp_buf, input int c0, input int e0,
                            input int clr_at, output logic [19:0] addr_l1);
    int c, e, err, nh, nvs, x, y, xp, yp;
    logic exp_re, exp_pv, exp_hs, exp_vs;
    logic [7:0] er, eg, eb;
    c = c0; e = e0; err = 0; nh = 0; nvs = 0;
    addr_l1 = '0;
    while (c < 12600) begin
      tick();
      c++;
      if (c == clr_at) begin
        buf1_full = 1'b0;
        buf2_full = 1'b0;
      end
      x = c % 120; y = c / 120;
      xp = (c - 1) % 120; yp = (c - 1) / 120;
      exp_re = (x < 100) && (y < 100);
      exp_pv = (xp < 100) && (yp < 100);
      exp_hs = (xp == 119);
      exp_vs = (c == 12600);
      if (re1 !== (exp_re && !exp_buf)) err++;
      if (re2 !== (exp_re && exp_buf)) err++;
      if (exp_re && addr !== 20'(y * 100 + x)) err++;
      if (pix_valid !== exp_pv) err++;
      if (hsync !== exp_hs) err++;
      if (vsync !== exp_vs) err++;
      if (frame_done !== vsync) err++;
      if (active_buf !== exp_buf) err++;
      if (pix_valid) begin
        er = exp_buf ? ~8'(e) : 8'(e);
        eg = 8'(e >> 8);
        eb = exp_buf ? 8'h5A : 8'hA5;
        if (pix_r !== er || pix_g !== eg || pix_b !== eb) err++;
        e++;
      end else if (pix_r !== 8'd0 || pix_g !== 8'd0 || pix_b !== 8'd0) begin
        err++;
      end
      if (c == 120) addr_l1 = addr;
      if (hsync) nh++;
      if (vsync) nvs++;
    end
    chk("frame_raster_errors", err, 0);
    chk("frame_pix_count", e, 10000);
    chk("frame_hsync_count", nh, 105);
    chk("frame_vsync_count", nvs, 1);
  endtask

  initial begin
    logic [19:0] al1;
    int n;
    tbl[0] = '{re1: 1'b1, re2: 1'b0, addr: 20'd0, pv: 1'b0, pr: 8'd0, hs: 1'b0};
    tbl[1] = '{re1: 1'b1, re2: 1'b0, addr: 20'd1, pv: 1'b1, pr: 8'd0, hs: 1'b0};
    tbl[2] = '{re1: 1'b1, re2: 1'b0, addr: 20'd2, pv: 1'b1, pr: 8'd1, hs: 1'b0};
    tbl[3] = '{re1: 1'b1, re2: 1'b0, addr: 20'd3, pv: 1'b1, pr: 8'd2, hs: 1'b0};
    tbl[4] = '{re1: 1'b1, re2: 1'b0, addr: 20'd4, pv: 1'b1, pr: 8'd3, hs: 1'b0};

    reset = 1'b1; buf1_full = 1'b0; buf2_full = 1'b0;
    repeat (3) tick();
    chk("rst_re1", re1, 0);
    chk("rst_re2", re2, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_addr", addr, 0);
    chk("rst_active_buf", active_buf, 0);
    chk("rst_sync", {hsync, vsync, frame_done}, 0);
    reset = 1'b0;

    n = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (re1 || re2 || pix_valid || pix_r != 8'd0 || hsync || vsync) n++;
    end
    chk("idle_quiet", n, 0);

    // Frame A on buffer 1: first cycles from the table, remainder from the raster model.
    buf1_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("start%0d_re1", k), re1, tbl[k].re1);
      chk($sformatf("start%0d_re2", k), re2, tbl[k].re2);
      chk($sformatf("start%0d_addr", k), addr, tbl[k].addr);
      chk($sformatf("start%0d_pix_valid", k), pix_valid, tbl[k].pv);
      chk($sformatf("start%0d_pix_r", k), pix_r, tbl[k].pr);
      chk($sformatf("start%0d_hsync", k), hsync, tbl[k].hs);
    end
    scan_frame(1'b0, 4, 4, -1, al1);
    chk("addr_line1", al1, 100);

    // Frame B repeats buffer 1, then ping-pong once buffer 2 is full.
    tick();
    chk("repeat_active_buf", active_buf, 0);
    chk("repeat_re1_addr0", {re1, addr}, {1'b1, 20'd0});
    buf2_full = 1'b1;
    scan_frame(1'b0, 0, 0, -1, al1);
    tick();
    chk("pp1_active_buf", active_buf, 1);
    chk("pp1_re", {re1, re2, pix_valid}, 3'b010);
    scan_frame(1'b1, 0, 0, -1, al1);
    tick();
    chk("pp2_active_buf", active_buf, 0);
    chk("pp2_re1", re1, 1);

    // Frame D: flags drop mid-frame, frame completes, then IDLE.
    scan_frame(1'b0, 0, 0, 3000, al1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (re1 || re2 || pix_valid) n++;
    end
    chk("after_clear_idle", n, 0);
    chk("after_clear_active_buf", active_buf, 0);

    // Reset at y=40, x=17.
    buf1_full = 1'b1;
    tick();
    repeat (40 * 120 + 17) tick();
    chk("midframe_addr", addr, 4017);
    chk("midframe_re1", re1, 1);
    reset = 1'b1;
    tick();
    chk("abort_re1", re1, 0);
    chk("abort_pix_valid", pix_valid, 0);
    chk("abort_addr", addr, 0);
    chk("abort_outputs", {hsync, vsync, frame_done, active_buf, pix_r}, 0);
    reset = 1'b0;
    tick();
    chk("restart_re1_addr0", {re1, addr}, {1'b1, 20'd0});
    tick();
    chk("restart_addr1", addr, 1);
    chk("restart_pix", {pix_valid, pix_r}, {1'b1, 8'd0});

    // Tie in IDLE: buffer 1 first, then buffer 2.
    reset = 1'b1; buf1_full = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("tie_idle", {re1, re2, pix_valid}, 0);
    buf1_full = 1'b1; buf2_full = 1'b1;
    tick();
    chk("tie_first_buf", {active_buf, re1, re2}, 3'b010);
    scan_frame(1'b0, 0, 0, -1, al1);
    tick();
    chk("tie_second_buf", {active_buf, re1, re2}, 3'b101);
    chk("tie_second_addr", addr, 0);
    tick();
    chk("tie_second_pix", {pix_valid, pix_r}, {1'b1, 8'hFF});
    buf1_full = 1'b0; buf2_full = 1'b0;

    chk("invariants", inv_err, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
